// File: rtl/pwm_duty_decoder_pkg.sv
// pwm_pkg: shared constants, types and helpers for the PWM duty decoder
package pwm_pkg;
   localparam int PWM_PERIOD   = 512;
   localparam int PWM_DUTY_W   = 8;
   localparam int PWM_DUTY_MAX = 2**PWM_DUTY_W - 1;
   localparam int PWM_CNT_W    = $clog2(PWM_PERIOD) + 1;
   localparam int PWM_SYNC_STG = 2;
   localparam int PWM_NCH      = 3;
   localparam int CH_R = 0;
   localparam int CH_G = 1;
   localparam int CH_B = 2;
   typedef logic [PWM_DUTY_W-1:0] duty_t;
   typedef logic [PWM_CNT_W-1:0]  cnt_t;
   typedef enum logic [1:0] {EV_NONE, EV_RISE, EV_FALL, EV_TIMEOUT} ev_e;
   function automatic duty_t sat_duty(cnt_t c);
      return (c > cnt_t'(PWM_DUTY_MAX)) ? duty_t'(PWM_DUTY_MAX) : duty_t'(c);
   endfunction
endpackage

// File: rtl/pwm_duty_decoder_if.sv
// pwm_duty_decoder_if: raw PWM lines in, decoded duty codes and update strobes out
interface pwm_duty_decoder_if;
   import pwm_pkg::*;
   logic [PWM_NCH-1:0] pwm_in;
   duty_t              duty_r;
   duty_t              duty_g;
   duty_t              duty_b;
   logic [PWM_NCH-1:0] duty_vld;
   modport master (output pwm_in, input duty_r, duty_g, duty_b, duty_vld);
   modport slave  (input pwm_in, output duty_r, duty_g, duty_b, duty_vld);
endinterface

// File: rtl/pwm_duty_decoder_chan_meas.sv
// pwm_chan_meas: one PWM line -> synchronise, measure high time, report duty with a strobe
module pwm_chan_meas
   import pwm_pkg::*;
#(
   parameter int SYNC_STG = PWM_SYNC_STG
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  pwm_i,
   output duty_t duty_o,
   output logic  vld_o
);
   logic [SYNC_STG-1:0] sync_q;
   logic                prev_q;
   logic                armed_q, armed_d;
   logic                vld_q, vld_d;
   cnt_t                hcnt_q, hcnt_d;
   cnt_t                idle_q, idle_d;
   duty_t               duty_q, duty_d;
   logic                synced;
   ev_e                 ev;
   assign synced = sync_q[SYNC_STG-1];
   // classify the cycle; an edge always beats a coinciding idle timeout
   always_comb begin
      ev = EV_NONE;
      if (synced != prev_q) ev = synced ? EV_RISE : EV_FALL;
      else if (idle_q == cnt_t'(PWM_PERIOD-1)) ev = EV_TIMEOUT;
   end
   // next-state: width counting, idle timeout, and duty/strobe update
   always_comb begin
      hcnt_d  = (ev == EV_RISE) ? cnt_t'(1) : (synced && hcnt_q != cnt_t'(PWM_PERIOD)) ? hcnt_q + 1'b1 : hcnt_q;
      idle_d  = (ev == EV_NONE) ? idle_q + 1'b1 : '0;
      armed_d = (ev == EV_RISE) ? 1'b1 : (ev == EV_TIMEOUT && synced) ? 1'b0 : armed_q;
      vld_d   = (ev == EV_FALL && armed_q) || ev == EV_TIMEOUT;
      duty_d  = (ev == EV_FALL && armed_q) ? sat_duty(hcnt_q) :
                (ev == EV_TIMEOUT) ? (synced ? duty_t'(PWM_DUTY_MAX) : '0) : duty_q;
   end
   // state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         vld_q   <= 1'b0;
         hcnt_q  <= '0;
         idle_q  <= '0;
         duty_q  <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STG-2:0], pwm_i};
         prev_q  <= synced;
         armed_q <= armed_d;
         vld_q   <= vld_d;
         hcnt_q  <= hcnt_d;
         idle_q  <= idle_d;
         duty_q  <= duty_d;
      end
   end
   assign duty_o = duty_q;
   assign vld_o  = vld_q;
endmodule

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: three independent channel meters mapped onto R/G/B duty outputs
module pwm_duty_decoder
   import pwm_pkg::*;
(
   input logic                clk,
   input logic                reset,
   pwm_duty_decoder_if.slave  bus
);
   duty_t              duty [PWM_NCH];
   logic [PWM_NCH-1:0] vld;
   genvar i;
   generate
      for (i = 0; i < PWM_NCH; i++) begin : g_ch
         pwm_chan_meas u_meas (
            .clk   (clk),
            .reset (reset),
            .pwm_i (bus.pwm_in[i]),
            .duty_o(duty[i]),
            .vld_o (vld[i])
         );
      end
   endgenerate
   assign bus.duty_r   = duty[CH_R];
   assign bus.duty_g   = duty[CH_G];
   assign bus.duty_b   = duty[CH_B];
   assign bus.duty_vld = vld;
endmodule
